// File: rtl/ir_align_pkg.sv
// Shared constants, pointer/count types and FSM state encoding for the
// instruction byte queue and aligner.
package ir_align_pkg;

  localparam int LINE_BYTES = 16;
  localparam int BUF_BYTES  = 32;
  localparam int MAX_LEN    = 15;

  localparam int PTR_W     = $clog2(BUF_BYTES);      // head pointer, mod 32
  localparam int CNT_W     = PTR_W + 1;              // 0..32 buffered bytes
  localparam int WIN_CNT_W = $clog2(LINE_BYTES) + 1; // 0..16 window bytes

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    ST_RUN,
    ST_REDIRECT
  } state_e;

endpackage

// File: rtl/ir_align_queue_rotator.sv
// Combinational 32-byte to 16-byte rotator: picks bytes head..head+15
// (mod 32) out of the buffer and zeroes window bytes at or beyond count.
// Byte 0 of both buffer and window sits in the most significant lane.
module ir_rotator
  import ir_align_pkg::*;
(
  input  logic [8*BUF_BYTES-1:0]  buffer,
  input  ptr_t                    head,
  input  logic [WIN_CNT_W-1:0]    count,
  output logic [8*LINE_BYTES-1:0] window
);

  ptr_t idx;

  // Rotate and mask: one byte mux per window lane, wrap via pointer width.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    window = '0;
    idx    = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      idx = head + ptr_t'(i);
      if (WIN_CNT_W'(i) < count)
        window[8*(LINE_BYTES-1-i) +: 8] = buffer[8*(BUF_BYTES-1-int'(idx)) +: 8];
    end
  end

endmodule

// File: rtl/ir_align_queue.sv
// Two-line instruction byte queue and aligner. Holds up to two 16-byte
// fetch lines and presents a window starting at the current instruction.
// Optional feature macro: IR_ALIGN_BYPASS_EN (an accepted line shows up in
// the window in the same cycle when the queue is empty).
module ir_align_queue #(
  parameter int LINE_BYTES = ir_align_pkg::LINE_BYTES,
  parameter int MAX_LEN    = ir_align_pkg::MAX_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_valid,
  input  logic [8*LINE_BYTES-1:0] fetch_line,
  output logic                    fetch_ready,
  output logic [8*LINE_BYTES-1:0] ir,
  output logic [4:0]              ir_count,
  input  logic                    consume_valid,
  input  logic [3:0]              consume_len,
  input  logic                    redirect,
  input  logic [3:0]              redirect_off,
  output logic                    protocol_err
);

  import ir_align_pkg::BUF_BYTES;
  import ir_align_pkg::PTR_W;
  import ir_align_pkg::ptr_t;
  import ir_align_pkg::cnt_t;
  import ir_align_pkg::state_e;
  import ir_align_pkg::ST_RUN;
  import ir_align_pkg::ST_REDIRECT;

  localparam int LINE_BITS = 8 * LINE_BYTES;

  state_e                 state_q, state_d;
  logic [3:0]             skip_q, skip_d;
  logic [1:0]             slot_v_q, slot_v_d;
  logic                   wr_slot_q, wr_slot_d;
  ptr_t                   head_q, head_d;
  cnt_t                   cnt_q, cnt_d;
  logic                   perr_q, perr_d;
  logic [8*BUF_BYTES-1:0] buf_q;

  logic                   accept;
  logic                   legal;
  cnt_t                   add_cnt;
  ptr_t                   head_acc;
  cnt_t                   cnt_acc;
  logic [8*BUF_BYTES-1:0] view_buf;
  ptr_t                   view_head;
  cnt_t                   view_cnt;

  assign fetch_ready  = ~slot_v_q[wr_slot_q];
  assign accept       = fetch_valid & fetch_ready;
  assign protocol_err = perr_q;

  // Head and count as they stand once this cycle's line is added; a line
  // arriving in REDIRECT drops the bytes before the branch target.
  always_comb begin
    add_cnt  = cnt_t'(LINE_BYTES);
    head_acc = head_q;
    if (state_q == ST_REDIRECT) begin
      add_cnt = cnt_t'(LINE_BYTES) - cnt_t'(skip_q);
      if (accept) head_acc = ptr_t'(skip_q);
    end
    cnt_acc = cnt_q + (accept ? add_cnt : cnt_t'(0));
  end

`ifdef IR_ALIGN_BYPASS_EN
  // Empty queue: show the incoming line through its destination slot now.
  always_comb begin
    view_buf  = buf_q;
    view_head = head_q;
    view_cnt  = cnt_q;
    if (accept && cnt_q == '0) begin
      if (wr_slot_q) view_buf[LINE_BITS-1:0]           = fetch_line;
      else           view_buf[2*LINE_BITS-1:LINE_BITS] = fetch_line;
      view_head = head_acc;
      view_cnt  = cnt_acc;
    end
  end
`else
  // Window always comes from registered state only.
  always_comb begin
    view_buf  = buf_q;
    view_head = head_q;
    view_cnt  = cnt_q;
  end
`endif

  assign ir_count = (view_cnt >= cnt_t'(LINE_BYTES)) ? 5'(LINE_BYTES) : view_cnt[4:0];

  ir_rotator u_rotator (
    .buffer (view_buf),
    .head   (view_head),
    .count  (ir_count),
    .window (ir)
  );

  assign legal = consume_valid && (consume_len != 4'd0) &&
                 (int'(consume_len) <= MAX_LEN) &&
                 ({1'b0, consume_len} <= ir_count);

  // Next-state: redirect wins; otherwise accept then legal consume stack up.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    slot_v_d  = slot_v_q;
    wr_slot_d = wr_slot_q;
    head_d    = head_q;
    cnt_d     = cnt_q;
    perr_d    = perr_q;
    if (redirect) begin
      state_d   = ST_REDIRECT;
      skip_d    = redirect_off;
      slot_v_d  = 2'b00;
      wr_slot_d = 1'b0;
      cnt_d     = '0;
    end else begin
      head_d = head_acc;
      cnt_d  = cnt_acc;
      if (accept) begin
        slot_v_d[wr_slot_q] = 1'b1;
        wr_slot_d           = ~wr_slot_q;
        state_d             = ST_RUN;
      end
      if (legal) begin
        head_d = head_acc + ptr_t'(consume_len);
        cnt_d  = cnt_acc - cnt_t'(consume_len);
        // A consume is shorter than a line, so it crosses at most one slot end.
        if (head_d[PTR_W-1] != head_acc[PTR_W-1])
          slot_v_d[head_acc[PTR_W-1]] = 1'b0;
      end else if (consume_valid) begin
        perr_d = 1'b1;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= ST_REDIRECT;
      skip_q    <= '0;
      slot_v_q  <= 2'b00;
      wr_slot_q <= 1'b0;
      head_q    <= '0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      slot_v_q  <= slot_v_d;
      wr_slot_q <= wr_slot_d;
      head_q    <= head_d;
      cnt_q     <= cnt_d;
      perr_q    <= perr_d;
    end
  end

  // Line storage: slot 0 in the upper half, slot 1 in the lower half.
  always_ff @(posedge clk) begin
    // NOTE: the byte buffer is deliberately not reset; cnt masks stale bytes.
    if (rst_n && accept && !redirect) begin
      if (wr_slot_q) buf_q[LINE_BITS-1:0]           <= fetch_line;
      else           buf_q[2*LINE_BITS-1:LINE_BITS] <= fetch_line;
    end
  end

endmodule

// File: doc/ir_align_queue.md
# ir_align_queue

Two-line instruction byte queue and aligner in front of the decode stage. It accepts 16-byte fetch lines, holds up to two lines, and presents a 128-bit window that always starts at the first byte of the current instruction. The immediate/displacement selectors and opcode decode can therefore index bytes at fixed positions. The decoder retires instructions by reporting their length, and a redirect discards all buffered bytes and realigns on a new target offset.

## Interface
Parameters:
- LINE_BYTES, 16, bytes per fetch line and per output window.
- MAX_LEN, 15, largest legal instruction length in bytes.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous and active-low. Sampled on the rising edge of clk.
- fetch_valid  in  1  fetch_line is valid this cycle.
- fetch_line  in  128  fetch line; byte 0 at [127:120], byte 15 at [7:0].
- fetch_ready  out  1  a line slot is free; a line is accepted when fetch_valid & fetch_ready.
- ir  out  128  aligned window; byte 0 (instruction start) at [127:120]; bytes at or beyond ir_count read as 0.
- ir_count  out  5  number of valid bytes in ir, 0..16.
- consume_valid  in  1  decoder retires an instruction this cycle.
- consume_len  in  4  length of the retired instruction, 1..15.
- redirect  in  1  flush the queue and realign.
- redirect_off  in  4  byte offset of the target inside the next accepted line.
- protocol_err  out  1  sticky illegal-consume flag.

## Operation
- Storage: 32-byte buffer in two line slots. Per-slot valid bit slot_v[1:0], write slot pointer wr_slot, head pointer head[4:0] (mod 32), and byte count cnt[5:0] from head to the end of valid data.
- Accept: the line is written into slot wr_slot. slot_v[wr_slot] is set, wr_slot toggles, and cnt increases by 16 (by 16-skip in REDIRECT).
- fetch_ready = ~slot_v[wr_slot].
- Consume is legal when 1 ≤ consume_len ≤ MAX_LEN and consume_len ≤ ir_count. On a legal consume:
  - head advances by consume_len (mod 32) and cnt decreases by consume_len.
  - A slot whose last byte is passed is invalidated that cycle.
- An illegal consume is ignored (no state change) and sets protocol_err, which stays set until reset.
- Window: ir = buffer bytes head..head+15 (mod 32); ir_count = min(cnt, 16).
- Simultaneous accept and legal consume: both apply. cnt' = cnt + added − consume_len. A slot freed by the consume is not reusable until the next cycle.
- States:
  - RUN: normal operation.
  - REDIRECT: queue empty, waiting for the target line; skip = redirect_off.
- Transitions:
  - redirect (any state): slot_v=0, cnt=0, wr_slot=0, skip latched, go to REDIRECT. The redirect has priority, so an accept or consume in the same cycle is discarded.
  - REDIRECT with an accept: the line goes into slot 0, head = skip, cnt = 16 − skip, go to RUN.
  - redirect while already in REDIRECT: re-latches skip.
- Reset values: state=REDIRECT, skip=0, slot_v=0, cnt=0, head=0, wr_slot=0, ir=0, ir_count=0, fetch_ready=1, protocol_err=0.

## Timing
- An accepted line appears in ir/ir_count on the next cycle (latency 1).
- A consume takes effect on the next cycle. ir is registered, with no combinational path from consume_* to ir.
- fetch_ready depends only on registered state.
- Head wrap: head = 30 with 4 valid bytes shows buffer bytes 30, 31, 0, 1.
- With two slots valid, fetch_ready = 0 until the consume that crosses a slot boundary. It rises on the following cycle.
- Reset asserted mid-stream clears all state in that cycle. Inputs in the reset cycle are ignored.

## Configuration
- IR_ALIGN_BYPASS_EN defined: when cnt = 0 in RUN or REDIRECT and a line is accepted, ir/ir_count reflect that line in the same cycle (shifted by skip in REDIRECT).
  - A consume against the bypassed window is legal in that cycle.
  - Result: zero-cycle latency on an empty queue.
- Not defined: latency is always 1 and ir depends only on registers.

## Structure
- Package ir_align_pkg:
  - constants LINE_BYTES, BUF_BYTES=32, MAX_LEN;
  - state enum {ST_RUN, ST_REDIRECT};
  - byte-count and pointer widths.
- Sub-module ir_rotator: a combinational 32-byte to 16-byte rotator. Inputs: buffer, head, count. It outputs the zero-masked window.
- The FSM and pointers live in ir_align_queue.

## Test plan
- Reset, then accept line L0 (bytes 00..0F) → next cycle ir_count=16, ir[127:120]=00, fetch_ready=1.
- Accept L0, then L1 (10..1F) → fetch_ready=0. Consume 5 → ir starts at 05, fetch_ready stays 0. Consume 12 (head 17) → slot 0 is freed and fetch_ready=1 the next cycle.
- Head wrap: run head to 30 with 4 bytes remaining → ir = 1E,1F,00',01',0… with ir_count=4. A consume of 5 is rejected and protocol_err=1 stays set.
- redirect with redirect_off=9 while both slots are full → queue empties (ir_count=0). Next line A0..AF → ir starts at A9, ir_count=7.
- Accept and consume 3 in the same cycle with cnt=6, one slot valid → cnt=19, ir starts at the old byte 3.
- With IR_ALIGN_BYPASS_EN, accept into an empty queue → ir valid in the same cycle, and a consume of 4 in that cycle leaves ir_count=12 next cycle. Without the macro, the same stimulus gives ir_count=0 in that cycle.
